path_sequencer: RTL

Sequences a precomputed hypercube route (up to 16 hop dimensions, 2-bit each, DIM=4) out to the router one hop at a time over a valid/ready handshake. It sits downstream of the path builder and upstream of the router output port selector. It latches a full path on `start`, tracks the current node address by flipping one address bit per accepted hop, and signals completion.

---
 rtl/path_seq_pkg.sv | 12 +
 rtl/path_sequencer_if.sv | 11 +
 rtl/path_sequencer_node_tracker.sv | 47 ++++
 rtl/path_sequencer.sv | 108 ++++++++++
 4 files changed

// File: rtl/path_seq_pkg.sv
// path_seq_pkg: shared widths and FSM state type for the hypercube path sequencer.
package path_seq_pkg;
    localparam int DIM      = 4;
    localparam int MAX_HOPS = 16;
    localparam int HOP_W    = 2;
    localparam int NODE_W   = DIM;
    localparam int IDX_W    = $clog2(MAX_HOPS);
    localparam int LEN_W    = IDX_W + 1;
    localparam int PATH_W   = HOP_W * MAX_HOPS;
    localparam int NODES    = 2 ** NODE_W;
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} seq_state_t;
endpackage

// File: rtl/path_sequencer_if.sv
// path_sequencer_if: hop offer bus from the sequencer (master) to the router (slave).
interface path_sequencer_if;
    import path_seq_pkg::*;
    logic              hop_valid;
    logic              hop_ready;
    logic [HOP_W-1:0]  hop_dim;
    logic [NODE_W-1:0] cur_node;
    logic [IDX_W-1:0]  hop_idx;
    modport master (output hop_valid, hop_dim, cur_node, hop_idx, input hop_ready);
    modport slave  (input hop_valid, hop_dim, cur_node, hop_idx, output hop_ready);
endinterface

// File: rtl/path_sequencer_node_tracker.sv
// node_tracker: current node register plus, with PATH_SEQ_REVISIT_CHECK_EN, a visited bitmap flagging revisits.
module node_tracker
    import path_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              fire,
    input  logic              last,
    input  logic [NODE_W-1:0] src_node,
    input  logic [HOP_W-1:0]  hop_dim,
    output logic [NODE_W-1:0] cur_node,
    output logic [NODE_W-1:0] next_node,
    output logic              illegal
);
    logic [NODE_W-1:0] cur_node_q, cur_node_d;
    assign cur_node  = cur_node_q;
    assign next_node = cur_node_q ^ (NODE_W'(1) << hop_dim);
    always_comb cur_node_d = load ? src_node : fire ? next_node : cur_node_q;
    always_ff @(posedge clk) begin
        if (!rst_n) cur_node_q <= '0;
        else        cur_node_q <= cur_node_d;
    end
`ifdef PATH_SEQ_REVISIT_CHECK_EN
    logic [NODE_W-1:0] src_q, src_d;
    logic [NODES-1:0]  visited_q, visited_d;
    // returning to the source on the final hop closes a legal cycle
    always_comb begin
        src_d     = load ? src_node : src_q;
        visited_d = load ? NODES'(1) << src_node : fire ? visited_q | NODES'(1) << next_node : visited_q;
        illegal   = fire && visited_q[next_node] && !(last && next_node == src_q);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_q     <= '0;
            visited_q <= '0;
        end else begin
            src_q     <= src_d;
            visited_q <= visited_d;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;
    assign illegal     = 1'b0;
`endif
endmodule

// File: rtl/path_sequencer.sv
// path_sequencer: streams a latched hypercube route one hop per valid/ready beat.
// Build with PATH_SEQ_REVISIT_CHECK_EN to add revisit detection and the err output.
module path_sequencer
    import path_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [NODE_W-1:0] src_node,
    input  logic [LEN_W-1:0]  path_len,
    input  logic [PATH_W-1:0] path_data,
    path_sequencer_if.master  hop,
    output logic              busy,
    output logic              done
`ifdef PATH_SEQ_REVISIT_CHECK_EN
    ,
    output logic              err
`endif
);
    seq_state_t        state_q, state_d;
    logic [PATH_W-1:0] path_q, path_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [IDX_W-1:0]  hop_idx_q, hop_idx_d, nxt_idx;
    logic [HOP_W-1:0]  hop_dim_q, hop_dim_d;
    logic              hop_valid_q, hop_valid_d, busy_q, busy_d, done_q, done_d;
    logic              load, fire, last, illegal;
    logic [NODE_W-1:0] unused_next_node;
    assign fire    = hop_valid_q && hop.hop_ready;
    assign load    = state_q == IDLE && start && !abort;
    assign last    = {1'b0, hop_idx_q} == len_q - 1'b1;
    assign nxt_idx = hop_idx_q + 1'b1;
    node_tracker u_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .fire      (fire),
        .last      (last),
        .src_node  (src_node),
        .hop_dim   (hop_dim_q),
        .cur_node  (hop.cur_node),
        .next_node (unused_next_node),
        .illegal   (illegal)
    );
    // hop_dim is prefetched for the next index so it is registered when offered
    always_comb begin
        state_d   = state_q;
        path_d    = path_q;
        len_d     = len_q;
        hop_idx_d = hop_idx_q;
        hop_dim_d = hop_dim_q;
        if (abort) begin
            state_d   = IDLE;
            hop_idx_d = '0;
        end else if (load) begin
            path_d    = path_data;
            len_d     = path_len > LEN_W'(MAX_HOPS) ? LEN_W'(MAX_HOPS) : path_len;
            hop_idx_d = '0;
            hop_dim_d = path_data[HOP_W-1:0];
            state_d   = path_len == '0 ? DONE : ISSUE;
        end else if (state_q == ISSUE && fire) begin
            hop_idx_d = nxt_idx;
            hop_dim_d = path_q[{nxt_idx, 1'b0} +: HOP_W];
            state_d   = last || illegal ? DONE : ISSUE;
        end else if (state_q == DONE) begin
            state_d   = IDLE;
            hop_idx_d = '0;
        end
        hop_valid_d = state_d == ISSUE;
        busy_d      = state_d != IDLE;
        done_d      = state_d == DONE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            path_q      <= '0;
            len_q       <= '0;
            hop_idx_q   <= '0;
            hop_dim_q   <= '0;
            hop_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            path_q      <= path_d;
            len_q       <= len_d;
            hop_idx_q   <= hop_idx_d;
            hop_dim_q   <= hop_dim_d;
            hop_valid_q <= hop_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end
    assign hop.hop_valid = hop_valid_q;
    assign hop.hop_dim   = hop_dim_q;
    assign hop.hop_idx   = hop_idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef PATH_SEQ_REVISIT_CHECK_EN
    logic err_q, err_d;
    always_comb err_d = load ? 1'b0 : illegal ? 1'b1 : err_q;
    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign err = err_q;
`endif
endmodule
